// File: rtl/afl_pkg.sv
// Shared constants, FSM state encoding and element type for the aligned window loader.
package afl_pkg;

  localparam int AFL_DIM_Y     = 128;
  localparam int INPUT_WIDTH   = 32;
  localparam int ELEMENT_WIDTH = 4;
  localparam int KERNEL_WIDTH  = 3;
  localparam int MAX_STRIDE    = 3;
  localparam int COL_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } afl_state_e;

  typedef logic [ELEMENT_WIDTH-1:0] afl_elem_t;

endpackage

// File: rtl/afl_feeder_lane.sv
// One feeder lane: a depth-deep tap shift register with synchronous clear and shift enable.
// Exposes the next-state taps so the parent can register a copy on the same edge.
module afl_feeder_lane #(
  parameter int depth = 3,
  parameter int width = 4
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         clear,
  input  logic                         shift,
  input  logic [width-1:0]             din,
  output logic [depth-1:0][width-1:0]  taps_next
);

  logic [depth-1:0][width-1:0] taps_reg;

  always_comb begin
    taps_next = taps_reg;
    if (clear) begin
      taps_next = '0;
    end else if (shift) begin
      taps_next[0] = din;
      for (int k = 1; k < depth; k++) begin
        taps_next[k] = taps_reg[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      taps_reg <= '0;
    end else begin
      taps_reg <= taps_next;
    end
  end

endmodule

// File: rtl/aligned_window_loader.sv
// Streams packed feature words onto offset-aligned feeder lanes and emits full
// kernel windows with a configurable column stride over a valid/ready handshake.
module aligned_window_loader
  import afl_pkg::*;
#(
  parameter int aflDimY      = AFL_DIM_Y,
  parameter int inputWidth   = INPUT_WIDTH,
  parameter int elementWidth = ELEMENT_WIDTH,
  parameter int kernelWidth  = KERNEL_WIDTH,
  parameter int maxStride    = MAX_STRIDE,
  parameter int colCntWidth  = COL_CNT_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic                                   start_i,
  input  logic [$clog2(maxStride+1)-1:0]         cfg_stride_i,
  input  logic [colCntWidth-1:0]                 cfg_num_cols_i,
  input  logic [$clog2(aflDimY/kernelWidth)-1:0] feeder_offset_i,
  input  logic [inputWidth-1:0]                  data_i,
  input  logic                                   valid_i,
  output logic                                   ready_o,
  output logic [aflDimY-1:0][elementWidth-1:0]   data_o,
  output logic                                   valid_o,
  input  logic                                   ready_i,
  output logic                                   busy_o,
  output logic                                   done_o
);

  localparam int NUM_FEEDERS = aflDimY / kernelWidth;
  localparam int OFF_W       = $clog2(NUM_FEEDERS);
  localparam int STRIDE_W    = $clog2(maxStride + 1);
  localparam int NEED_W      = $clog2(kernelWidth + 1);
  localparam int LANE_BITS   = NUM_FEEDERS * elementWidth;

  afl_state_e               state_reg, state_next;
  logic [NEED_W-1:0]        need_reg, need_next;
  logic [colCntWidth-1:0]   col_reg, col_next;
  logic [colCntWidth-1:0]   num_cols_reg;
  logic [STRIDE_W-1:0]      stride_reg;
  logic [OFF_W-1:0]         off_reg;
  logic                     clear_taps;
  logic                     accept;
  logic [LANE_BITS-1:0]     aligned_flat;
  logic [aflDimY-1:0][elementWidth-1:0]     window_next;
  logic [aflDimY-1:0][elementWidth-1:0]     data_reg;
  logic [kernelWidth-1:0][elementWidth-1:0] lane_taps_next [NUM_FEEDERS];

  assign ready_o = (state_reg == FILL);
  assign valid_o = (state_reg == EMIT);
  assign busy_o  = (state_reg != IDLE);
  assign done_o  = (state_reg == DONE);
  assign accept  = valid_i & ready_o;
  assign data_o  = data_reg;

  // Shifting the whole word up by off lanes drops anything past the last feeder.
  always_comb begin
    aligned_flat = LANE_BITS'(data_i) << (off_reg * elementWidth);
  end

  genvar gi, gk;
  generate
    for (gi = 0; gi < NUM_FEEDERS; gi++) begin : g_lane
      afl_feeder_lane #(
        .depth (kernelWidth),
        .width (elementWidth)
      ) u_lane (
        .clk       (clk),
        .srst      (nrst),
        .clear     (clear_taps),
        .shift     (accept),
        .din       (aligned_flat[gi*elementWidth +: elementWidth]),
        .taps_next (lane_taps_next[gi])
      );
      for (gk = 0; gk < kernelWidth; gk++) begin : g_tap
        assign window_next[gi*kernelWidth + gk] = lane_taps_next[gi][gk];
      end
    end
    for (gi = NUM_FEEDERS * kernelWidth; gi < aflDimY; gi++) begin : g_pad
      assign window_next[gi] = '0;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    need_next  = need_reg;
    col_next   = col_reg;
    clear_taps = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          clear_taps = 1'b1;
          col_next   = '0;
          need_next  = NEED_W'(kernelWidth);
          state_next = (cfg_num_cols_i == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (accept) begin
          need_next = need_reg - NEED_W'(1);
          if (need_reg == NEED_W'(1)) begin
            state_next = EMIT;
          end
        end
      end
      EMIT: begin
        if (ready_i) begin
          if (col_reg == num_cols_reg - colCntWidth'(1)) begin
            state_next = DONE;
          end else begin
            col_next   = col_reg + colCntWidth'(1);
            need_next  = NEED_W'(stride_reg);
            state_next = FILL;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_reg    <= IDLE;
      need_reg     <= '0;
      col_reg      <= '0;
      num_cols_reg <= '0;
      stride_reg   <= STRIDE_W'(1);
      off_reg      <= '0;
      data_reg     <= '0;
    end else begin
      state_reg <= state_next;
      need_reg  <= need_next;
      col_reg   <= col_next;
      // Lane taps only move on accept or clear, so this copy is stable otherwise.
      data_reg  <= window_next;
      if (state_reg == IDLE && start_i) begin
        num_cols_reg <= cfg_num_cols_i;
        stride_reg   <= (cfg_stride_i == '0) ? STRIDE_W'(1) : cfg_stride_i;
        off_reg      <= feeder_offset_i;
      end
    end
  end

endmodule

// File: tb/tb_aligned_window_loader.sv
// Self-checking bench: table-driven jobs plus random jobs against a word-history window model.
module tb_aligned_window_loader;
  import afl_pkg::*;

  localparam int K  = 3;
  localparam int NF = 42;
  localparam int IE = 8;

  typedef logic [127:0][3:0] win_t;

  typedef struct {
    int stride;
    int ncols;
    int off;
    int mode;      // 0: always valid/ready, 1: random handshakes, 2: constant word 0x87654321
    int bp;        // cycles of held-off ready_i on the first window
    int exp_words;
  } vec_t;

  logic        clk;
  logic        nrst;
  logic        start_i;
  logic [1:0]  cfg_stride_i;
  logic [7:0]  cfg_num_cols_i;
  logic [5:0]  feeder_offset_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  win_t        data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  int job_id = 0;
  logic [31:0] words [$];
  vec_t tbl [8];

  aligned_window_loader dut (
    .clk             (clk),
    .nrst            (nrst),
    .start_i         (start_i),
    .cfg_stride_i    (cfg_stride_i),
    .cfg_num_cols_i  (cfg_num_cols_i),
    .feeder_offset_i (feeder_offset_i),
    .data_i          (data_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s job=%0d act=%0h exp=%0h", name, job_id, act, exp);
    end
  endtask

  // Window after n accepted words: lane L tap k is element (L-off) of word n-1-k.
  function automatic win_t model_window(input int off);
    win_t w;
    afl_elem_t e;
    int n;
    w = '0;
    n = words.size();
    for (int L = 0; L < NF; L++) begin
      for (int k = 0; k < K; k++) begin
        if ((n - 1 - k) >= 0 && L >= off && (L - off) < IE) begin
          e = 4'(words[n-1-k] >> ((L - off) * 4));
          w[L*K + k] = e;
        end
      end
    end
    return w;
  endfunction

  task automatic run_job(input int stride, input int ncols, input int off,
                         input int mode, input int bp, input int exp_words);
    int  stride_eff;
    int  col;
    int  cyc;
    int  bp_left;
    bit  finished;
    bit  acc;
    bit  hs;
    stride_eff = (stride == 0) ? 1 : stride;
    col = 0;
    cyc = 0;
    bp_left = bp;
    finished = 0;
    words.delete();
    start_i         = 1'b1;
    cfg_stride_i    = 2'(stride);
    cfg_num_cols_i  = 8'(ncols);
    feeder_offset_i = 6'(off);
    valid_i         = 1'b0;
    ready_i         = 1'b0;
    @(posedge clk); #1;
    start_i         = 1'b0;
    cfg_stride_i    = 2'($urandom);
    cfg_num_cols_i  = 8'($urandom);
    feeder_offset_i = 6'($urandom);
    cyc = 1;
    check("busy", 512'(busy_o), 512'(1));
    while (!finished && cyc < 4000) begin
      if (done_o) begin
        check("done_cols", 512'(col), 512'(ncols));
        check("words", 512'(words.size()), 512'(exp_words));
        if (ncols == 0) check("done_lat", 512'(cyc), 512'(1));
        $display("job %0d done cols=%0d words=%0d", job_id, col, words.size());
        finished = 1;
      end else begin
        if (valid_o) begin
          check("window", 512'(data_o), 512'(model_window(off)));
          check("win_words", 512'(words.size()), 512'(K + col * stride_eff));
          check("ready_emit", 512'(ready_o), 512'(0));
          if (bp_left > 0) begin
            ready_i = 1'b0;
            bp_left--;
          end else begin
            ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (ready_i) $display("window job=%0d col=%0d words=%0d", job_id, col, words.size());
        end else begin
          ready_i = 1'($urandom_range(0, 1));
        end
        if (bp > 0 && valid_o) valid_i = 1'b1;
        else valid_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        data_i = (mode == 2) ? 32'h8765_4321 : $urandom;
        acc = valid_i && ready_o;
        hs  = valid_o && ready_i;
        @(posedge clk); #1;
        cyc++;
        if (acc) words.push_back(data_i);
        if (hs) col++;
      end
    end
    if (!finished) check("timeout", 512'(0), 512'(1));
    valid_i = 1'b0;
    ready_i = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", 512'(done_o), 512'(0));
    check("idle", 512'(busy_o), 512'(0));
    job_id++;
  endtask

  initial begin
    int stride;
    int ncols;
    int off;
    tbl[0] = '{1, 4,   0,  0, 0,  6};
    tbl[1] = '{1, 1,   5,  2, 0,  3};
    tbl[2] = '{2, 3,   0,  1, 0,  7};
    tbl[3] = '{1, 2,   7,  0, 10, 4};
    tbl[4] = '{3, 0,   9,  1, 0,  0};
    tbl[5] = '{0, 3,   41, 1, 0,  5};
    tbl[6] = '{3, 4,   38, 1, 0,  12};
    tbl[7] = '{1, 255, 0,  0, 0,  257};

    nrst = 1'b1;
    start_i = 1'b0; cfg_stride_i = '0; cfg_num_cols_i = '0; feeder_offset_i = '0;
    data_i = '0; valid_i = 1'b0; ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_i = 1'($urandom); valid_i = 1'($urandom); ready_i = 1'($urandom);
      data_i = $urandom; cfg_num_cols_i = 8'($urandom);
      @(posedge clk); #1;
      check("rst_outs", 512'({valid_o, ready_o, busy_o, done_o}), 512'(0));
      check("rst_data", 512'(data_o), 512'(0));
      $display("reset cycle %0d", i);
    end
    nrst = 1'b0; start_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 512'({busy_o, ready_o}), 512'(0));

    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i].stride, tbl[i].ncols, tbl[i].off, tbl[i].mode, tbl[i].bp, tbl[i].exp_words);
      if (i == 1) begin
        for (int L = 5; L <= 12; L++) check("off5_lane", 512'(data_o[L*K]), 512'(L - 4));
        check("off5_lane4", 512'(data_o[4*K]), 512'(0));
        check("off5_lane13", 512'(data_o[13*K]), 512'(0));
        check("pad_rows", 512'({data_o[127], data_o[126]}), 512'(0));
      end
    end

    for (int j = 0; j < 6; j++) begin
      stride = $urandom_range(0, 3);
      ncols  = $urandom_range(0, 6);
      off    = $urandom_range(0, NF - 1);
      run_job(stride, ncols, off, 1, 0,
              (ncols == 0) ? 0 : K + (ncols - 1) * ((stride == 0) ? 1 : stride));
      check("pad_rows_rand", 512'({data_o[127], data_o[126]}), 512'(0));
    end

    // Reset during FILL abandons the job without a done pulse.
    start_i = 1'b1; cfg_stride_i = 2'd1; cfg_num_cols_i = 8'd2; feeder_offset_i = 6'd0;
    @(posedge clk); #1;
    start_i = 1'b0; valid_i = 1'b1; data_i = 32'h1111_1111;
    check("fill_ready", 512'(ready_o), 512'(1));
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("fill_tap0", 512'(data_o[0]), 512'(1));
    nrst = 1'b1;
    @(posedge clk); #1;
    nrst = 1'b0;
    check("midrst_outs", 512'({valid_o, ready_o, busy_o, done_o}), 512'(0));
    check("midrst_data", 512'(data_o), 512'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_nodone", 512'({busy_o, done_o}), 512'(0));
    end
    $display("mid-fill reset sequence complete");

    run_job(2, 2, 0, 0, 0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
